// File: rtl/sa_psum_drain_pkg.sv
// mfu_pkg: shared drain FSM encoding and width helpers for the systolic-array psum drain.
package mfu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    localparam int unsigned PSUM_SCALE = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    function automatic int unsigned psum_width(input int unsigned dw);
        return PSUM_SCALE * dw;
    endfunction

    // Index ports keep at least one bit so a 1-row or 1-column array still elaborates.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PSUM_WIDTH = psum_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/sa_psum_drain_if.sv
// Valid/ready word stream leaving the psum drain, tagged with row/column indices.
interface sa_psum_drain_if
    import mfu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned S_WIDTH    = 2,
    parameter int unsigned S_HEIGHT   = 2
);
    logic                                valid;
    logic                                ready;
    logic [psum_width(DATA_WIDTH)-1:0]   data;
    logic [idx_width(S_HEIGHT)-1:0]      row;
    logic [idx_width(S_WIDTH)-1:0]       col;

    modport master (output valid, data, row, col, input ready);
    modport slave  (input valid, data, row, col, output ready);
endinterface

// File: rtl/sa_psum_drain.sv
// Drains a systolic array column by column into a valid/ready word stream.
// Optional build macro SA_DRAIN_SAT_EN clamps captured words to the signed operand range.
module sa_psum_drain
    import mfu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned S_WIDTH    = 2,
    parameter int unsigned S_HEIGHT   = 2
) (
    input  logic                                          i_clk,
    input  logic                                          i_nrst,
    input  logic                                          i_start,
    output logic                                          o_psum_out_en,
    input  logic [0:S_HEIGHT-1][psum_width(DATA_WIDTH)-1:0] i_psum,
    output logic                                          o_valid,
    input  logic                                          i_ready,
    output logic [psum_width(DATA_WIDTH)-1:0]             o_data,
    output logic [idx_width(S_HEIGHT)-1:0]                o_row,
    output logic [idx_width(S_WIDTH)-1:0]                 o_col,
    output logic                                          o_busy,
    output logic                                          o_done
);

    localparam int unsigned PW = psum_width(DATA_WIDTH);
    localparam int unsigned RW = idx_width(S_HEIGHT);
    localparam int unsigned CW = idx_width(S_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(S_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(S_WIDTH - 1);

    drain_state_e                state_q, state_d;
    logic [RW-1:0]               row_q, row_d;
    logic [CW-1:0]               col_q, col_d;
    logic [0:S_HEIGHT-1][PW-1:0] row_buf;
    logic [0:S_HEIGHT-1][PW-1:0] cap_words;

`ifdef SA_DRAIN_SAT_EN
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        cap_words = i_psum;
        for (int unsigned r = 0; r < S_HEIGHT; r++) begin
            if ($signed(i_psum[RW'(r)]) > SAT_MAX) begin
                cap_words[RW'(r)] = SAT_MAX;
            end else if ($signed(i_psum[RW'(r)]) < SAT_MIN) begin
                cap_words[RW'(r)] = SAT_MIN;
            end
        end
    end
`else
    always_comb begin
        cap_words = i_psum;
    end
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            row_buf <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (state_q == ST_SHIFT) begin
                row_buf <= cap_words;
            end
        end
    end

    // The array is only strobed from SHIFT, which is reached once the buffer is fully sent.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        o_psum_out_en = 1'b0;
        o_valid       = 1'b0;
        o_busy        = 1'b1;
        o_done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_busy = 1'b0;
                row_d  = '0;
                col_d  = '0;
                if (i_start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_psum_out_en = 1'b1;
                row_d         = '0;
                state_d       = ST_EMIT;
            end
            ST_EMIT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    if (row_q != ROW_LAST) begin
                        row_d = row_q + 1'b1;
                    end else if (col_q != COL_LAST) begin
                        col_d   = col_q + 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_data = '0;
        o_row  = '0;
        o_col  = '0;
        if (state_q == ST_EMIT) begin
            o_data = row_buf[row_q];
            o_row  = row_q;
            o_col  = col_q;
        end
    end

endmodule

// File: tb/tb_sa_psum_drain.sv
// Self-checking bench for sa_psum_drain: table-driven drains, scoreboard on the word stream, hand-written corner sequences.
module tb_sa_psum_drain;
    import mfu_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned H  = 2;
    localparam int unsigned DW = DEFAULT_DATA_WIDTH;
    localparam int unsigned PW = PSUM_WIDTH;

    logic               clk = 1'b0;
    logic               nrst;
    logic               start;
    logic               en;
    logic [0:H-1][PW-1:0] psum;
    logic               busy;
    logic               done;

    sa_psum_drain_if #(.DATA_WIDTH(DW), .S_WIDTH(W), .S_HEIGHT(H)) bus ();

    logic               start1;
    logic               en1;
    logic [0:0][PW-1:0] psum1;
    logic               valid1;
    logic               ready1;
    logic [PW-1:0]      data1;
    logic               row1;
    logic               col1;
    logic               busy1;
    logic               done1;

    always #5 clk = ~clk;

    sa_psum_drain #(.DATA_WIDTH(DW), .S_WIDTH(W), .S_HEIGHT(H)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_start(start), .o_psum_out_en(en), .i_psum(psum),
        .o_valid(bus.valid), .i_ready(bus.ready), .o_data(bus.data), .o_row(bus.row),
        .o_col(bus.col), .o_busy(busy), .o_done(done)
    );

    sa_psum_drain #(.DATA_WIDTH(DW), .S_WIDTH(1), .S_HEIGHT(1)) dut1 (
        .i_clk(clk), .i_nrst(nrst), .i_start(start1), .o_psum_out_en(en1), .i_psum(psum1),
        .o_valid(valid1), .i_ready(ready1), .o_data(data1), .o_row(row1),
        .o_col(col1), .o_busy(busy1), .o_done(done1)
    );

    typedef struct packed {
        logic [3:0][PW-1:0] in_w;
        logic [3:0][PW-1:0] exp_w;
    } vec_t;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          row;
        logic          col;
    } exp_t;

    vec_t vecs [4];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur_vec = 0;
    int   shift_idx = 0;
    int   words_seen = 0;
    int   done_seen = 0;

    logic          s_en, s_valid, s_busy, s_done, s_row, s_col;
    logic [PW-1:0] s_data;
    logic          s1_en, s1_valid, s1_busy, s1_done, s1_row, s1_col;
    logic [PW-1:0] s1_data;

    function automatic vec_t mk(input logic [PW-1:0] i0, i1, i2, i3, e0, e1, e2, e3);
        vec_t v;
        v.in_w[0] = i0; v.in_w[1] = i1; v.in_w[2] = i2; v.in_w[3] = i3;
        v.exp_w[0] = e0; v.exp_w[1] = e1; v.exp_w[2] = e2; v.exp_w[3] = e3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // One clock: sample at negedge, run scoreboard and array model, return just after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_en = en; s_valid = bus.valid; s_busy = busy; s_done = done;
        s_data = bus.data; s_row = bus.row; s_col = bus.col;
        s1_en = en1; s1_valid = valid1; s1_busy = busy1; s1_done = done1;
        s1_data = data1; s1_row = row1; s1_col = col1;
        if (!nrst) begin
            sb.delete();
            shift_idx = 0;
        end
        if (s_done) done_seen++;
        if (s_valid && bus.ready) begin
            words_seen++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL word: unexpected word %0h at row %0d col %0d, none expected", s_data, s_row, s_col);
            end else begin
                e = sb.pop_front();
                chk("word {data,row,col}", 32'({s_data, s_row, s_col}), 32'({e.data, e.row, e.col}));
            end
        end
        if (s_en) begin
            if (shift_idx >= int'(W)) begin
                n_tests++;
                n_fail++;
                $display("FAIL shift: got shift %0d expected at most %0d", shift_idx + 1, W);
            end else begin
                for (int r = 0; r < int'(H); r++) begin
                    psum[1'(r)] = vecs[cur_vec].in_w[2'(shift_idx * int'(H) + r)];
                    e.data = vecs[cur_vec].exp_w[2'(shift_idx * int'(H) + r)];
                    e.row  = 1'(r);
                    e.col  = 1'(shift_idx);
                    sb.push_back(e);
                end
                shift_idx++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        chk({name, " ctl {en,valid,busy,done}"}, 32'({en, bus.valid, busy, done}), 32'(4'b0000));
        chk({name, " data"}, 32'(bus.data), 32'(0));
        chk({name, " {row,col}"}, 32'({bus.row, bus.col}), 32'(2'b00));
    endtask

    task automatic run_drain(input int v);
        logic [11:0] en_h, done_h, busy_h;
        int w0;
        cur_vec = v;
        shift_idx = 0;
        w0 = words_seen;
        bus.ready = 1'b1;
        start = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            en_h[t] = s_en; done_h[t] = s_done; busy_h[t] = s_busy;
            if (t == 0) start = 1'b0;
        end
        chk($sformatf("v%0d psum_out_en cycles", v), 32'(en_h), 32'(12'b0000_0001_0010));
        chk($sformatf("v%0d done cycle", v), 32'(done_h), 32'(12'b0000_1000_0000));
        chk($sformatf("v%0d busy cycles", v), 32'(busy_h), 32'(12'b0000_1111_1110));
        chk($sformatf("v%0d word count", v), 32'(words_seen - w0), 32'(4));
        chk($sformatf("v%0d scoreboard empty", v), 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] en_h, done_h;
        logic [5:0]  en1_h, valid1_h, done1_h, busy1_h;
        int w0, d0;

        vecs[0] = mk(16'd5, 16'd7, 16'd9, 16'd11, 16'd5, 16'd7, 16'd9, 16'd11);
        vecs[1] = mk(16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h8000);
`ifdef SA_DRAIN_SAT_EN
        vecs[2] = mk(16'h012C, 16'hFF38, 16'h007F, 16'hFF80, 16'h007F, 16'hFF80, 16'h007F, 16'hFF80);
        vecs[3] = mk(16'hFFFF, 16'h0080, 16'hFF7F, 16'h1234, 16'hFFFF, 16'h007F, 16'hFF80, 16'h007F);
        vecs[1] = mk(16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'hFF80);
`else
        vecs[2] = mk(16'h012C, 16'hFF38, 16'h007F, 16'hFF80, 16'h012C, 16'hFF38, 16'h007F, 16'hFF80);
        vecs[3] = mk(16'hFFFF, 16'h0080, 16'hFF7F, 16'h1234, 16'hFFFF, 16'h0080, 16'hFF7F, 16'h1234);
`endif

        nrst = 1'b0; start = 1'b0; bus.ready = 1'b0; psum = '0;
        start1 = 1'b0; ready1 = 1'b1; psum1[0] = 16'h0042;
        tick();
        tick();
        check_idle("reset");
        nrst = 1'b1;
        tick();
        check_idle("idle after reset");

        for (int v = 0; v < 4; v++) begin
            run_drain(v);
        end

        // Backpressure on word (1,0) for three cycles.
        cur_vec = 0; shift_idx = 0; w0 = words_seen; start = 1'b1;
        for (int t = 0; t < 14; t++) begin
            bus.ready = !(t >= 3 && t <= 5);
            tick();
            en_h[t] = s_en; done_h[t] = s_done;
            if (t == 0) start = 1'b0;
            if (t >= 3 && t <= 5)
                chk($sformatf("stall hold c%0d {valid,en,data,row,col}", t),
                    32'({s_valid, s_en, s_data, s_row, s_col}), 32'({1'b1, 1'b0, 16'd7, 1'b1, 1'b0}));
        end
        chk("stall psum_out_en cycles", 32'(en_h), 32'(14'b00_0000_1000_0010));
        chk("stall done cycle", 32'(done_h), 32'(14'b00_0100_0000_0000));
        chk("stall word count", 32'(words_seen - w0), 32'(4));
        bus.ready = 1'b1;

        // Start pulses while busy (EMIT and DONE) must be ignored.
        cur_vec = 1; shift_idx = 0; w0 = words_seen; d0 = done_seen;
        for (int t = 0; t < 12; t++) begin
            start = (t == 0 || t == 2 || t == 5 || t == 7);
            tick();
            en_h[t] = s_en; done_h[t] = s_done;
        end
        start = 1'b0;
        chk("ignore start psum_out_en cycles", 32'(en_h[11:0]), 32'(12'b0000_0001_0010));
        chk("ignore start done cycle", 32'(done_h[11:0]), 32'(12'b0000_1000_0000));
        chk("ignore start word count", 32'(words_seen - w0), 32'(4));
        chk("ignore start done count", 32'(done_seen - d0), 32'(1));

        // Reset after the second word abandons the drain.
        cur_vec = 0; shift_idx = 0; w0 = words_seen; start = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (t == 0) start = 1'b0;
        end
        chk("pre-reset word count", 32'(words_seen - w0), 32'(2));
        nrst = 1'b0;
        #1;
        check_idle("async reset mid-drain");
        tick();
        nrst = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        chk("post-reset no words", 32'(words_seen - w0), 32'(2));
        check_idle("idle after mid-drain reset");
        run_drain(0);

        // 1x1 array: one shift, one word, done three cycles after start.
        start1 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            en1_h[t] = s1_en; valid1_h[t] = s1_valid; done1_h[t] = s1_done; busy1_h[t] = s1_busy;
            if (t == 0) start1 = 1'b0;
            if (t == 2)
                chk("1x1 word {data,row,col}", 32'({s1_data, s1_row, s1_col}), 32'({16'h0042, 1'b0, 1'b0}));
        end
        chk("1x1 psum_out_en cycles", 32'(en1_h), 32'(6'b000010));
        chk("1x1 valid cycles", 32'(valid1_h), 32'(6'b000100));
        chk("1x1 done cycle", 32'(done1_h), 32'(6'b001000));
        chk("1x1 busy cycles", 32'(busy1_h), 32'(6'b001110));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_psum_drain.md
SA_PSUM_DRAIN -- requirements
Module: sa_psum_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width; psum width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter S_WIDTH, default 2, array columns, i.e. shifts per drain.
REQ-003 SHALL have parameter S_HEIGHT, default 2, array rows, i.e. words per shift.
REQ-004 SHALL have port i_clk, input, 1 bit, single clock; all state on rising edge.
REQ-005 SHALL have port i_nrst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1 bit, request a full drain of the array.
REQ-007 SHALL have port o_psum_out_en, output, 1 bit, shift strobe to the array's i_psum_out_en.
REQ-008 SHALL have port i_psum, input, [0:S_HEIGHT-1][2*DATA_WIDTH-1:0], array row outputs (column-0 PE values).
REQ-009 SHALL have port o_valid, output, 1 bit, output word valid.
REQ-010 SHALL have port i_ready, input, 1 bit, downstream accepts word.
REQ-011 SHALL have port o_data, output, 2*DATA_WIDTH bits, psum word.
REQ-012 SHALL have port o_row, output, $clog2(S_HEIGHT) bits (min 1), row index of o_data.
REQ-013 SHALL have port o_col, output, $clog2(S_WIDTH) bits (min 1), column index of o_data.
REQ-014 SHALL have port o_busy, output, 1 bit, high in any state other than IDLE.
REQ-015 SHALL have port o_done, output, 1 bit, one-cycle pulse when the drain completes.

Function
REQ-016 SHALL implement FSM IDLE, SHIFT, EMIT, DONE.
REQ-017 IDLE: i_start=1 SHALL move to SHIFT next cycle with column counter=0; i_start in any other state SHALL be ignored.
REQ-018 SHIFT: o_psum_out_en SHALL be 1 for exactly this one cycle; at its closing edge all S_HEIGHT words of i_psum SHALL be captured into a row buffer, and the FSM SHALL go to EMIT with row counter=0.
REQ-019 o_psum_out_en SHALL be 0 in every state but SHIFT; the array is never shifted while the buffer holds unsent words.
REQ-020 EMIT: o_valid=1; o_data=buffer[row], o_row=row, o_col=column; a transfer occurs on a cycle with o_valid&i_ready.
REQ-021 While o_valid=1 and i_ready=0, o_data/o_row/o_col SHALL hold stable; o_valid SHALL NOT drop before the transfer.
REQ-022 On transfer with row<S_HEIGHT-1: row+1, stay EMIT; with row=S_HEIGHT-1 and column<S_WIDTH-1: column+1, go SHIFT; with both last: go DONE.
REQ-023 DONE SHALL assert o_done for one cycle and return to IDLE; o_busy SHALL be 0 in that next IDLE cycle.
REQ-024 With i_ready held 1, a drain SHALL take S_WIDTH*(1+S_HEIGHT) cycles from first SHIFT to last transfer, o_done on the following cycle.
REQ-025 Output order SHALL be column-major: col 0 rows 0..S_HEIGHT-1, then col 1, etc.
REQ-026 S_HEIGHT=1 and S_WIDTH=1 SHALL work (counters wrap immediately, index ports read 0).

Reset
REQ-027 i_nrst=0 SHALL asynchronously force IDLE, counters 0, buffer 0; o_valid, o_psum_out_en, o_busy, o_done 0; o_data, o_row, o_col 0.
REQ-028 Reset mid-drain SHALL abandon the drain; no partial words emitted after release; a new i_start restarts from column 0.

Configuration
REQ-029 Macro SA_DRAIN_SAT_EN defined: captured words SHALL be clamped, as signed values, to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], sign-extended to 2*DATA_WIDTH on o_data.
REQ-030 Macro undefined: words SHALL pass unmodified; no clamp logic instantiated.

Structure
REQ-031 The FSM state enum and psum-width localparam SHALL live in shared package mfu_pkg.
REQ-032 The block SHALL be a single module; no sub-module.

Verification
REQ-033 2x2, i_ready=1, column 0 rows = {5,7}, column 1 rows = {9,11} after shift -> o_data 5,7,9,11 with (row,col) (0,0),(1,0),(0,1),(1,1); o_psum_out_en on cycles 1 and 4; o_done on cycle 7.
REQ-034 i_ready=0 for 3 cycles at word (1,0) -> o_valid held, o_data stable, o_psum_out_en stays 0 until the transfer.
REQ-035 i_start pulsed during EMIT -> ignored; exactly 4 words and one o_done.
REQ-036 Reset asserted after second word -> all outputs 0 immediately; new i_start re-emits from (0,0).
REQ-037 SA_DRAIN_SAT_EN, DATA_WIDTH=8, inputs 16'sd300 and -16'sd200 -> 127 and -128; without macro -> 300 and -200.
REQ-038 S_WIDTH=1, S_HEIGHT=1 -> one SHIFT, one word, o_done three cycles after i_start.
